// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point definitions for the RNN datapath: Q(QN).(QM) element format,
// serializer state encoding and the packed-vector element extractor.
package rnn_fixed_pkg;

    localparam int QN       = 6;
    localparam int QM       = 11;
    localparam int BITWIDTH = QN + QM + 1;
    localparam int MAX_NCOL = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } ser_state_t;

    // Callers zero-extend narrower vectors to MAX_NCOL elements before calling.
    function automatic logic signed [BITWIDTH-1:0] elem_at(
        input logic [BITWIDTH*MAX_NCOL-1:0] vec,
        input int unsigned                  k
    );
        return $signed(vec[k*BITWIDTH +: BITWIDTH]);
    endfunction

endpackage

// File: rtl/vec_holdbuf.sv
// One-entry vector holding register: load captures din and marks it valid,
// consume releases the entry. Load wins if both are raised together.
module vec_holdbuf #(
    parameter int W = 288
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         consume,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vec_serializer.sv
// Streams one packed layer vector per handshake to dot_prod, one element per cycle
// with its weight column address, then waits for dataReady before the next stream.
module vec_serializer
    import rnn_fixed_pkg::*;
#(
    parameter int NCOL           = 16,
    parameter int ADDR_BITWIDTH  = 4,
    parameter int LAYER_BITWIDTH = BITWIDTH * NCOL
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LAYER_BITWIDTH-1:0]  vecIn,
    input  logic                       vecValid,
    output logic                       vecReady,
    input  logic                       hold,
    input  logic                       dotDone,
    output logic signed [BITWIDTH-1:0] elemOut,
    output logic                       elemValid,
    output logic [ADDR_BITWIDTH-1:0]   colAddress,
    output logic                       lastElem,
    output logic                       protoErr
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(NCOL - 1);

    ser_state_t                   state, state_nxt;
    logic [ADDR_BITWIDTH-1:0]     idx;
    logic [LAYER_BITWIDTH-1:0]    cur;
    logic [LAYER_BITWIDTH-1:0]    pend;
    logic [BITWIDTH*MAX_NCOL-1:0] cur_wide;
    logic                         pend_v;
    logic                         accept;
    logic                         issue_last;
    logic                         dot_exit;
    logic                         take_new;
    logic                         pend_load;
    logic                         pend_consume;

    assign accept       = vecValid & vecReady;
    assign issue_last   = elemValid & (idx == LAST_IDX);
    assign dot_exit     = (state == WAIT) & dotDone;
    assign pend_consume = dot_exit & pend_v;
    // A vector arriving as WAIT exits with nothing pending skips pend and goes straight to cur.
    assign take_new     = accept & ((state == IDLE) | (dot_exit & ~pend_v));
    assign pend_load    = accept & ~take_new;

    vec_holdbuf #(
        .W(LAYER_BITWIDTH)
    ) u_pend (
        .clock   (clock),
        .reset   (reset),
        .load    (pend_load),
        .din     (vecIn),
        .consume (pend_consume),
        .valid   (pend_v),
        .dout    (pend)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = STREAM;
            STREAM:  if (issue_last) state_nxt = WAIT;
            WAIT:    if (dotDone) state_nxt = (pend_v | accept) ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vecReady   = 1'b0;
        elemValid  = 1'b0;
        lastElem   = 1'b0;
        colAddress = '0;
        elemOut    = '0;
        cur_wide   = '0;
        cur_wide[LAYER_BITWIDTH-1:0] = cur;
        if (reset) begin
            vecReady   = (state == IDLE) | ~pend_v;
            elemValid  = (state == STREAM) & ~hold;
            lastElem   = elemValid & (idx == LAST_IDX);
            colAddress = idx;
            elemOut    = elem_at(cur_wide, 32'(idx));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur      <= '0;
            idx      <= '0;
            protoErr <= 1'b0;
        end else begin
            if (take_new) begin
                cur <= vecIn;
                idx <= '0;
            end else if (pend_consume) begin
                cur <= pend;
                idx <= '0;
            end else if (elemValid) begin
                idx <= issue_last ? '0 : idx + 1'b1;
            end
            if (dotDone && (state != WAIT)) begin
                protoErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed bench for vec_serializer: expected elements are queued at each accepted
// handshake and compared whenever the DUT presents an element.
module tb_vec_serializer;
    import rnn_fixed_pkg::*;

    localparam int NCOL = 16;
    localparam int AW   = 4;
    localparam int LW   = BITWIDTH * NCOL;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [LW-1:0]              vecIn;
    logic                       vecValid;
    logic                       vecReady;
    logic                       hold;
    logic                       dotDone;
    logic signed [BITWIDTH-1:0] elemOut;
    logic                       elemValid;
    logic [AW-1:0]              colAddress;
    logic                       lastElem;
    logic                       protoErr;

    typedef struct packed {
        logic [BITWIDTH-1:0] d;
        logic [AW-1:0]       a;
        logic                l;
    } exp_t;

    exp_t                sbq[$];
    logic [BITWIDTH-1:0] ev [NCOL];
    int                  n_checks = 0;
    int                  n_pass   = 0;
    int                  n_fail   = 0;
    int                  elem_total = 0;
    int                  base;
    int                  span;
    bit                  found;

    vec_serializer #(
        .NCOL          (NCOL),
        .ADDR_BITWIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .vecIn      (vecIn),
        .vecValid   (vecValid),
        .vecReady   (vecReady),
        .hold       (hold),
        .dotDone    (dotDone),
        .elemOut    (elemOut),
        .elemValid  (elemValid),
        .colAddress (colAddress),
        .lastElem   (lastElem),
        .protoErr   (protoErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle at the falling edge and score any presented element.
    task automatic sample();
        exp_t e;
        @(negedge clock);
        if (elemValid) begin
            elem_total++;
            chk("sb_entry_avail", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("elemOut", 32'($unsigned(elemOut)), 32'(e.d));
                chk("colAddress", 32'(colAddress), 32'(e.a));
                chk("lastElem", 32'(lastElem), 32'(e.l));
            end
        end else begin
            chk("lastElem_no_valid", 32'(lastElem), 0);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        sample();
        next();
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < NCOL; k++) begin
            case (mode)
                0:       ev[k] = BITWIDTH'(k + 1);
                1:       ev[k] = BITWIDTH'(-(k + 1));
                default: ev[k] = BITWIDTH'($urandom);
            endcase
            vecIn[k*BITWIDTH +: BITWIDTH] = ev[k];
        end
    endtask

    task automatic push_vec();
        for (int k = 0; k < NCOL; k++) begin
            sbq.push_back('{d: ev[k], a: AW'(k), l: (k == NCOL - 1)});
        end
    endtask

    task automatic offer(input int mode, input string tag);
        fill(mode);
        vecValid = 1'b1;
        sample();
        chk(tag, 32'(vecReady), 1);
        if (vecReady) push_vec();
        next();
        vecValid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && sbq.size() != 0; i++) step();
        chk(tag, 32'(sbq.size()), 0);
    endtask

    task automatic pulse_done();
        dotDone = 1'b1;
        step();
        dotDone = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks so far %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        vecValid = 1'b1;
        hold     = 1'b0;
        dotDone  = 1'b0;
        vecIn    = '1;
        next();
        sample();
        chk("rst_vecReady", 32'(vecReady), 0);
        chk("rst_elemValid", 32'(elemValid), 0);
        chk("rst_elemOut", 32'($unsigned(elemOut)), 0);
        chk("rst_colAddress", 32'(colAddress), 0);
        chk("rst_protoErr", 32'(protoErr), 0);
        next();
        reset    = 1'b1;
        vecValid = 1'b0;
        vecIn    = '0;
        sample();
        chk("idle_vecReady", 32'(vecReady), 1);
        chk("idle_elemValid", 32'(elemValid), 0);
        next();

        // Single ramp vector 1..16
        base = elem_total;
        offer(0, "t1_accept");
        sample();
        chk("t1_first_valid", 32'(elemValid), 1);
        chk("t1_first_val", 32'($unsigned(elemOut)), 1);
        next();
        drain("t1_drain");
        chk("t1_count", 32'(elem_total - base), 16);
        sample();
        chk("t1_wait_elemValid", 32'(elemValid), 0);
        chk("t1_wait_vecReady", 32'(vecReady), 1);
        next();
        pulse_done();

        // Back-to-back: second vector buffered while the first streams
        sample();
        chk("t2_idle_ready", 32'(vecReady), 1);
        next();
        offer(2, "t2_accept_a");
        step();
        step();
        step();
        offer(1, "t2_accept_b");
        sample();
        chk("t2_ready_low", 32'(vecReady), 0);
        next();
        for (int i = 0; i < 40 && sbq.size() > NCOL; i++) step();
        sample();
        chk("t2_wait_elemValid", 32'(elemValid), 0);
        chk("t2_wait_ready_low", 32'(vecReady), 0);
        next();
        pulse_done();
        sample();
        chk("t2_b_first_valid", 32'(elemValid), 1);
        chk("t2_b_first", 32'($unsigned(elemOut)), 'h3FFFF);
        chk("t2_protoErr", 32'(protoErr), 0);
        next();
        drain("t2_drain");
        pulse_done();

        // Three hold cycles at idx 5
        base = elem_total;
        span = 0;
        offer(0, "t3_accept");
        for (int i = 0; i < 5; i++) begin
            step();
            span++;
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_hold_gap", 32'(elemValid), 0);
            chk("t3_hold_idx", 32'(colAddress), 5);
            next();
            span++;
        end
        hold = 1'b0;
        sample();
        chk("t3_resume", 32'($unsigned(elemOut)), 6);
        next();
        span++;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            step();
            span++;
        end
        chk("t3_count", 32'(elem_total - base), 16);
        chk("t3_span", 32'(span), 19);
        pulse_done();

        // dotDone during STREAM is a protocol error and does not disturb the stream
        base = elem_total;
        offer(2, "t4_accept");
        step();
        step();
        pulse_done();
        sample();
        chk("t4_protoErr_set", 32'(protoErr), 1);
        next();
        drain("t4_drain");
        chk("t4_count", 32'(elem_total - base), 16);
        sample();
        chk("t4_wait_elemValid", 32'(elemValid), 0);
        chk("t4_protoErr_sticky", 32'(protoErr), 1);
        next();
        pulse_done();
        sample();
        chk("t4_idle_ready", 32'(vecReady), 1);
        chk("t4_protoErr_held", 32'(protoErr), 1);
        next();

        // Reset at idx 9 with a vector pending
        offer(0, "t5_accept_x");
        step();
        offer(1, "t5_accept_y");
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            sample();
            if (elemValid && colAddress == AW'(9)) begin
                found = 1'b1;
                reset = 1'b0;
                sbq.delete();
            end
            next();
        end
        chk("t5_reached_idx9", 32'(found), 1);
        sample();
        chk("t5_rst_elemValid", 32'(elemValid), 0);
        chk("t5_rst_vecReady", 32'(vecReady), 0);
        chk("t5_rst_elemOut", 32'($unsigned(elemOut)), 0);
        chk("t5_rst_colAddress", 32'(colAddress), 0);
        chk("t5_rst_protoErr", 32'(protoErr), 0);
        next();
        reset = 1'b1;
        sample();
        chk("t5_rel_vecReady", 32'(vecReady), 1);
        chk("t5_rel_elemValid", 32'(elemValid), 0);
        chk("t5_rel_elemOut", 32'($unsigned(elemOut)), 0);
        next();
        base = elem_total;
        for (int i = 0; i < 12; i++) step();
        chk("t5_no_spurious", 32'(elem_total - base), 0);

        // Accept and dotDone together in WAIT with nothing pending
        offer(2, "t6_accept_a");
        drain("t6_drain_a");
        fill(2);
        vecValid = 1'b1;
        dotDone  = 1'b1;
        sample();
        chk("t6_ready", 32'(vecReady), 1);
        if (vecReady) push_vec();
        next();
        vecValid = 1'b0;
        dotDone  = 1'b0;
        sample();
        chk("t6_first_valid", 32'(elemValid), 1);
        chk("t6_first_addr", 32'(colAddress), 0);
        next();
        drain("t6_drain_b");
        chk("t6_protoErr", 32'(protoErr), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_serializer.md
# vec_serializer

Transmit side of the dot-product element stream. Accepts one NCOL-element fixed-point layer vector per handshake and presents it to `dot_prod` one element per cycle, together with the matching `colAddress` for `weightRAM`. It then holds off the next stream until `dot_prod` raises `dataReady`. A one-entry pending buffer lets the next vector be accepted while the current one is streaming or being reduced.

## Interface
- `NCOL`, 16, elements per vector
- `QN`, 6, integer bits of a Q(QN).(QM) element
- `QM`, 11, fraction bits
- `BITWIDTH`, QN+QM+1 = 18, signed element width
- `LAYER_BITWIDTH`, BITWIDTH*NCOL, packed vector width
- `ADDR_BITWIDTH`, 4, column address width; must satisfy 2^ADDR_BITWIDTH ≥ NCOL
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `vecIn` in LAYER_BITWIDTH: packed vector; element k is `vecIn[k*BITWIDTH +: BITWIDTH]`.
- `vecValid` in 1: `vecIn` is valid.
- `vecReady` out 1: the block can accept a vector.
- `hold` in 1: downstream stall; freezes the stream.
- `dotDone` in 1: driven by `dot_prod` `dataReady`.
- `elemOut` out BITWIDTH: signed element, fed to `dot_prod` `inputVec`.
- `elemValid` out 1: `elemOut`/`colAddress` valid this cycle.
- `colAddress` out ADDR_BITWIDTH: element index; equals the weight column.
- `lastElem` out 1: high with element NCOL-1.
- `protoErr` out 1: sticky; set if `dotDone` arrives outside WAIT.

## Operation
- States:
  - IDLE: no vector loaded.
  - STREAM: issuing elements.
  - WAIT: all elements issued; waiting for `dotDone`.
- Two vector registers:
  - `cur` holds the vector being issued.
  - `pend` holds the next vector, with valid bit `pendV`.
- Accept condition: a vector is accepted when `vecValid & vecReady` at a rising edge.
- `vecReady` (combinational) = reset deasserted & (state==IDLE | !pendV).
- Accept in IDLE: load `cur`, idx←0, go to STREAM.
- Accept in STREAM/WAIT: load `pend`, pendV←1.
- Element output:
  - `elemValid` = (state==STREAM) & !hold.
  - `elemOut` = `cur` element idx.
  - `colAddress` = idx.
  - `lastElem` = elemValid & (idx==NCOL-1).
- Indexing: idx advances only on edges where `elemValid`=1. On the edge that issues element NCOL-1, go to WAIT and set idx←0.
- WAIT with `dotDone`=1:
  - If pendV=1: `cur`←`pend`, pendV←0, go to STREAM.
  - Otherwise go to IDLE.
- Simultaneous accept and `dotDone` in WAIT with pendV=0: the incoming vector goes directly into `cur`, state goes to STREAM, `pend` is untouched.
- `dotDone` in IDLE or STREAM is ignored for sequencing and sets `protoErr`.
- Data path: elements pass through bit-exact. No arithmetic, saturation or sign handling beyond the width.

## Timing
- Reset values: state IDLE, idx 0, pendV 0, `protoErr` 0, `cur`/`pend` 0. During reset `elemValid`, `lastElem` and `vecReady` are 0, and `elemOut` and `colAddress` are 0.
- Reset mid-stream or mid-WAIT aborts immediately; `cur` and `pend` are discarded.
- Latency: accept at edge E0 → element 0 is valid in the cycle following E0. Element k is valid in the cycle following E0+k when `hold` stays low.
- Stream length: exactly NCOL `elemValid` cycles per vector. `hold` cycles insert gaps without repeating or skipping an element.
- WAIT exit: the earliest exit is the edge where `dotDone` is sampled high. The next stream's element 0 appears in the following cycle, giving one bubble minimum between streams.
- `hold` has no effect outside STREAM.

## Structure
- Shared package `rnn_fixed_pkg` holds:
  - QN, QM, BITWIDTH
  - the state enum (IDLE, STREAM, WAIT)
  - the element-extract helper function.
- Sub-module `vec_holdbuf`: one-entry vector register with load/valid/consume. It is instantiated for `pend`; `cur` is plain registers in the top level.
- Integration: top level instantiates next to `dot_prod` and `weightRAM`, with `colAddress` shared.

## Test plan
- Single vector, element k = k+1 raw (0x00001..0x00010): accept at E0 → 16 cycles with elemOut = 1..16 and colAddress = 0..15, `lastElem` only at value 16; then WAIT with `vecReady`=1.
- Back-to-back: the second vector (element k = -(k+1), i.e. 0x3FFFF downward) is accepted during STREAM, so `vecReady` drops to 0. `dotDone` pulse → second stream starts in the next cycle, first elemOut 0x3FFFF.
- `hold` high for 3 cycles at idx 5: elemValid=0 for 3 cycles, idx stays 5, and elemOut 6 resumes exactly once; the stream is 19 cycles total.
- `dotDone` pulsed during STREAM: stream unaffected, `protoErr`=1 and stays 1 until reset.
- `reset`=0 at idx 9 with pendV=1: the next cycle has all outputs at reset values. After release, `vecReady`=1 and no element is emitted without a new handshake.
- WAIT with `dotDone` and `vecValid` both high in the same cycle, pendV=0: the new vector is accepted and element 0 appears in the next cycle.
